axis_video_checker: RTL and testbench

- Synthesizable, passive monitor for the AXI-Stream video output of the pixel generator; checks SOF (tuser), EOL (tlast), line length, frame height, handshake stability and stall timeout.
- Exposes sticky error flags, saturating counters and a per-frame checksum so on-chip debug logic can read them.
- Sits in parallel with the stream; it never drives tready.

---
 rtl/axis_video_checker.sv | 210 +++++++++++++++++++++
 tb/tb_axis_video_checker.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_checker.sv
`default_nettype none
// ============================================================================
//  Module      : axis_video_checker
//  Description : Passive AXI-Stream video protocol monitor. It checks SOF/EOL
//                framing, line length, frame height, handshake stability and
//                stall timeout. It exposes sticky error flags, saturating
//                statistics counters and a per-frame data checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_video_checker #(
    parameter int DATA_W  = 32,
    parameter int X_SIZE  = 150,
    parameter int Y_SIZE  = 200,
    parameter int TIMEOUT = 10000,
    parameter int CNT_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [DATA_W-1:0]             tdata,
    input  logic                          tvalid,
    input  logic                          tready,
    input  logic                          tuser,
    input  logic                          tlast,
    output logic [5:0]                    err_flags,
    output logic [CNT_W-1:0]              err_count,
    output logic [CNT_W-1:0]              frame_count,
    output logic [CNT_W-1:0]              beat_count,
    output logic [CNT_W-1:0]              stall_count,
    output logic                          frame_done,
    output logic [DATA_W-1:0]             frame_checksum,
    output logic [$clog2(X_SIZE+1)-1:0]   x_pos,
    output logic [$clog2(Y_SIZE+1)-1:0]   y_pos
);

    localparam int XW = $clog2(X_SIZE + 1);
    localparam int YW = $clog2(Y_SIZE + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    localparam logic [XW-1:0] X_LAST    = XW'(X_SIZE - 1);
    localparam logic [XW-1:0] X_MAX     = {XW{1'b1}};
    localparam logic [YW-1:0] Y_LAST    = YW'(Y_SIZE - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    // Error flag bit positions
    localparam int E_MISS_SOF  = 0;
    localparam int E_UNEXP_SOF = 1;
    localparam int E_LONG      = 2;
    localparam int E_SHORT     = 3;
    localparam int E_STABLE    = 4;
    localparam int E_TIMEOUT   = 5;

    localparam logic [0:0] S_WAIT_SOF = 1'b0;
    localparam logic [0:0] S_IN_FRAME = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [DATA_W-1:0] r_acc;
    logic [IW-1:0]     r_idle;
    logic              r_prev_stall;
    logic [DATA_W-1:0] r_prev_data;
    logic              r_prev_user;
    logic              r_prev_last;

    logic              w_beat;
    logic              w_stall;
    logic              w_start;
    logic [XW-1:0]     w_x_eff;
    logic [YW-1:0]     w_y_eff;
    logic [XW-1:0]     w_x_next;
    logic [YW-1:0]     w_y_next;
    logic [DATA_W-1:0] w_acc_next;
    logic              w_frame_end;
    logic [5:0]        w_ev;
    logic [2:0]        w_ev_n;

    // Saturating add of a small increment to a statistics counter
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Qualified handshake terms; a tuser beat or a beat in WAIT_SOF anchors x/y at the origin
    always_comb begin
        w_beat  = enable & tvalid & tready;
        w_stall = enable & tvalid & ~tready;
        w_start = (r_state == S_WAIT_SOF) | tuser;
        w_x_eff = w_start ? '0 : x_pos;
        w_y_eff = w_start ? '0 : y_pos;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_WAIT_SOF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: a beat without SOF keeps waiting, the last line of a frame returns to WAIT_SOF
    always_comb begin
        w_state_next = r_state;
        if (w_beat) begin
            if ((r_state == S_WAIT_SOF) && !tuser) begin
                w_state_next = S_WAIT_SOF;
            end else if (tlast && (w_y_eff == Y_LAST)) begin
                w_state_next = S_WAIT_SOF;
            end else begin
                w_state_next = S_IN_FRAME;
            end
        end
    end

    // FSM outputs: position update, checksum accumulation and per-cycle error events
    always_comb begin
        w_ev        = '0;
        w_frame_end = 1'b0;
        w_x_next    = x_pos;
        w_y_next    = y_pos;
        w_acc_next  = r_acc;
        if (w_beat) begin
            if ((r_state == S_WAIT_SOF) && !tuser) begin
                w_ev[E_MISS_SOF] = 1'b1;
            end else begin
                w_ev[E_UNEXP_SOF] = (r_state == S_IN_FRAME) & tuser;
                w_acc_next        = w_start ? tdata : r_acc + tdata;
                w_ev[E_LONG]      = (w_x_eff == X_LAST) & ~tlast;
                w_ev[E_SHORT]     = tlast & (w_x_eff < X_LAST);
                if (tlast) begin
                    w_x_next = '0;
                    if (w_y_eff == Y_LAST) begin
                        w_frame_end = 1'b1;
                        w_y_next    = '0;
                    end else begin
                        w_y_next = w_y_eff + YW'(1);
                    end
                end else begin
                    w_x_next = (w_x_eff == X_MAX) ? X_MAX : w_x_eff + XW'(1);
                    w_y_next = w_y_eff;
                end
            end
        end
        w_ev[E_STABLE]  = enable & r_prev_stall &
                          (~tvalid | (tdata != r_prev_data) |
                           (tuser != r_prev_user) | (tlast != r_prev_last));
        w_ev[E_TIMEOUT] = enable & ~tvalid & (r_idle == IDLE_LAST);
        w_ev_n = '0;
        for (int i = 0; i < 6; i++) begin
            w_ev_n = w_ev_n + {2'b00, w_ev[i]};
        end
    end

    // Frame datapath: position, accumulator, checksum latch and stall history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_pos          <= '0;
            y_pos          <= '0;
            r_acc          <= '0;
            frame_done     <= 1'b0;
            frame_checksum <= '0;
            r_prev_stall   <= 1'b0;
            r_prev_data    <= '0;
            r_prev_user    <= 1'b0;
            r_prev_last    <= 1'b0;
            r_idle         <= '0;
        end else begin
            x_pos        <= w_x_next;
            y_pos        <= w_y_next;
            r_acc        <= w_acc_next;
            frame_done   <= w_frame_end;
            if (w_frame_end) begin
                frame_checksum <= w_acc_next;
            end
            r_prev_stall <= w_stall;
            r_prev_data  <= tdata;
            r_prev_user  <= tuser;
            r_prev_last  <= tlast;
            if (enable) begin
                if (tvalid || (r_idle == IDLE_LAST)) begin
                    r_idle <= '0;
                end else begin
                    r_idle <= r_idle + IW'(1);
                end
            end
        end
    end

    // Sticky flags and saturating counters; same-cycle events survive a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flags   <= '0;
            err_count   <= '0;
            frame_count <= '0;
            beat_count  <= '0;
            stall_count <= '0;
        end else begin
            err_flags   <= (clear ? 6'd0 : err_flags) | w_ev;
            err_count   <= sat_add(clear ? '0 : err_count,   w_ev_n);
            frame_count <= sat_add(clear ? '0 : frame_count, {2'b00, w_frame_end});
            beat_count  <= sat_add(clear ? '0 : beat_count,  {2'b00, w_beat});
            stall_count <= sat_add(clear ? '0 : stall_count, {2'b00, w_stall});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_video_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_video_checker
//  Description : Randomized self-checking bench for axis_video_checker with a
//                behavioural reference model and a checksum scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axis_video_checker;

    localparam int DATA_W  = 32;
    localparam int X_SIZE  = 4;
    localparam int Y_SIZE  = 3;
    localparam int TIMEOUT = 20;
    localparam int CNT_W   = 32;
    localparam int XW      = $clog2(X_SIZE + 1);
    localparam int YW      = $clog2(Y_SIZE + 1);
    localparam int XMAX    = (1 << XW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b1;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] tdata = '0;
    logic              tvalid = 1'b0;
    logic              tready = 1'b0;
    logic              tuser = 1'b0;
    logic              tlast = 1'b0;
    logic [5:0]        err_flags;
    logic [CNT_W-1:0]  err_count, frame_count, beat_count, stall_count;
    logic              frame_done;
    logic [DATA_W-1:0] frame_checksum;
    logic [XW-1:0]     x_pos;
    logic [YW-1:0]     y_pos;

    always #5 clk = ~clk;

    axis_video_checker #(
        .DATA_W(DATA_W), .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .tdata(tdata), .tvalid(tvalid), .tready(tready), .tuser(tuser), .tlast(tlast),
        .err_flags(err_flags), .err_count(err_count), .frame_count(frame_count),
        .beat_count(beat_count), .stall_count(stall_count), .frame_done(frame_done),
        .frame_checksum(frame_checksum), .x_pos(x_pos), .y_pos(y_pos)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_in_frame;
    int          m_x, m_y, m_idle;
    logic [31:0] m_sum;
    bit          m_pst, m_pu, m_pl;
    logic [31:0] m_pd;
    logic [5:0]  m_flags;
    logic [31:0] m_err, m_frames, m_beats, m_stalls;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_x = 0; m_y = 0; m_idle = 0; m_sum = 0;
        m_pst = 0; m_pu = 0; m_pl = 0; m_pd = 0;
        m_flags = 0; m_err = 0; m_frames = 0; m_beats = 0; m_stalls = 0;
    endtask

    // One sampled cycle of the protocol rules
    task automatic model_step(input bit v, input bit r, input bit u, input bit l,
                              input logic [31:0] d, input bit clr);
        logic [5:0] ev;
        bit fe, bt, st;
        ev = 0; fe = 0; bt = 0; st = 0;
        if (enable) begin
            if (m_pst && (!v || d !== m_pd || u !== m_pu || l !== m_pl)) ev[4] = 1;
            if (!v) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin ev[5] = 1; m_idle = 0; end
            end else begin
                m_idle = 0;
            end
            st = v && !r;
            if (v && r) begin
                bt = 1;
                if (!m_in_frame && !u) begin
                    ev[0] = 1;
                end else begin
                    if (u) begin
                        if (m_in_frame) ev[1] = 1;
                        m_x = 0; m_y = 0; m_sum = d;
                    end else begin
                        m_sum = m_sum + d;
                    end
                    m_in_frame = 1;
                    if (m_x == X_SIZE - 1 && !l) ev[2] = 1;
                    if (l && m_x < X_SIZE - 1) ev[3] = 1;
                    if (l) begin
                        m_x = 0;
                        if (m_y == Y_SIZE - 1) begin
                            m_y = 0; m_in_frame = 0; fe = 1;
                            exp_q.push_back(m_sum);
                        end else begin
                            m_y++;
                        end
                    end else if (m_x < XMAX) begin
                        m_x++;
                    end
                end
            end
            m_pst = st; m_pd = d; m_pu = u; m_pl = l;
        end else begin
            m_pst = 0;
        end
        if (clr) begin
            m_flags = 0; m_err = 0; m_beats = 0; m_frames = 0; m_stalls = 0;
        end
        m_flags  = m_flags | ev;
        m_err    = m_err + $countones(ev);
        m_beats  = m_beats + 32'(bt);
        m_frames = m_frames + 32'(fe);
        m_stalls = m_stalls + 32'(st);
    endtask

    task automatic drive(input bit v, input bit r, input bit u, input bit l,
                         input logic [31:0] d, input bit clr = 1'b0);
        tvalid = v; tready = r; tuser = u; tlast = l; tdata = d; clear = clr;
        model_step(v, r, u, l, d, clr);
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".err_flags"},   64'(err_flags),   64'(m_flags));
        chk({tag, ".err_count"},   64'(err_count),   64'(m_err));
        chk({tag, ".frame_count"}, 64'(frame_count), 64'(m_frames));
        chk({tag, ".beat_count"},  64'(beat_count),  64'(m_beats));
        chk({tag, ".stall_count"}, 64'(stall_count), 64'(m_stalls));
        chk({tag, ".x_pos"},       64'(x_pos),       64'(m_x));
        chk({tag, ".y_pos"},       64'(y_pos),       64'(m_y));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tvalid = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // A frame with three lines of the given lengths; tdata is the beat index
    task automatic send_frame(input int l0, input int l1, input int l2, input bit chk_sof);
        int lens[3];
        int idx;
        lens = '{l0, l1, l2};
        idx = 0;
        for (int ln = 0; ln < 3; ln++) begin
            for (int b = 0; b < lens[ln]; b++) begin
                drive(1, 1, idx == 0, b == lens[ln] - 1, 32'(idx));
                if (chk_sof && idx == 0) begin
                    chk("sof_resync_x", 64'(x_pos), 64'd1);
                    chk("sof_resync_y", 64'(y_pos), 64'd0);
                end
                idx++;
            end
        end
    endtask

    // Scoreboard monitor: each frame_done pulse must match the next expected checksum
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && frame_done) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL frame_done: got pulse with checksum %0d expected no frame", frame_checksum);
            end else begin
                e = exp_q.pop_front();
                if (frame_checksum !== e) begin
                    fails++;
                    $display("FAIL frame_checksum: got %0d expected %0d", frame_checksum, e);
                end
            end
        end
    end

    initial begin
        int nstall;
        bit r;
        logic [31:0] d;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Two clean frames, always ready
        send_frame(4, 4, 4, 0);
        send_frame(4, 4, 4, 0);
        check_all("clean");
        chk("clean.frame_count", 64'(frame_count), 64'd2);
        chk("clean.beat_count", 64'(beat_count), 64'd24);
        chk("clean.checksum", 64'(frame_checksum), 64'd66);
        chk("clean.flags", 64'(err_flags), 64'd0);

        // Short line 1
        drive(0, 0, 0, 0, 0, 1);
        send_frame(4, 3, 4, 0);
        check_all("short");
        chk("short.flags", 64'(err_flags), 64'b001000);
        chk("short.err_count", 64'(err_count), 64'd1);
        chk("short.beats", 64'(beat_count), 64'd11);

        // Long line 0
        drive(0, 0, 0, 0, 0, 1);
        send_frame(5, 4, 4, 0);
        check_all("long");
        chk("long.flags", 64'(err_flags), 64'b000100);

        // Unexpected SOF on beat 5
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 1, i == 0, i % 4 == 3, 32'(i));
        send_frame(4, 4, 4, 1);
        check_all("unexp_sof");
        chk("unexp_sof.flags", 64'(err_flags), 64'b000010);
        chk("unexp_sof.frames", 64'(frame_count), 64'd1);

        // Random backpressure with data changes while stalled
        drive(0, 0, 0, 0, 0, 1);
        nstall = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 12; i++) begin
                d = $urandom;
                for (int t = 0; t < 16; t++) begin
                    if (f == 0 && i == 0 && t == 0) r = 0;
                    else if (t == 15) r = 1;
                    else r = $urandom_range(0, 1);
                    drive(1, r, i == 0, i % 4 == 3, d);
                    if (r) break;
                    nstall++;
                    if ((f == 0 && i == 0 && t == 0) || $urandom_range(0, 3) == 0) d = d ^ 32'h1;
                end
            end
        end
        check_all("random");
        chk("random.stall_count", 64'(stall_count), 64'(nstall));
        chk("random.stable_flag", 64'(err_flags[4]), 64'd1);

        // Timeout: 45 idle cycles give two events
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 44; i++) drive(0, 0, 0, 0, 0);
        check_all("timeout");
        chk("timeout.err_count", 64'(err_count), 64'd2);
        chk("timeout.flags", 64'(err_flags), 64'b100000);

        // Clear coincident with the second timeout event
        pulse_reset();
        for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 0, i == 39);
        check_all("timeout_clear");
        chk("timeout_clear.flags", 64'(err_flags), 64'b100000);
        chk("timeout_clear.err_count", 64'(err_count), 64'd1);

        // Reset in the middle of a frame, then a clean frame
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) drive(1, 1, i == 0, i % 4 == 3, 32'(i));
        pulse_reset();
        send_frame(4, 4, 4, 0);
        check_all("mid_reset");
        chk("mid_reset.flags", 64'(err_flags), 64'd0);
        chk("mid_reset.frames", 64'(frame_count), 64'd1);

        // Disabled monitoring freezes everything
        enable = 1'b0;
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 32'(i));
        drive(1, 0, 0, 0, 32'd9);
        check_all("disabled");
        enable = 1'b1;
        drive(0, 0, 0, 0, 0);
        check_all("reenabled");

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
